// File: rtl/quad_paddle_pkg.sv
// Shared pong package: screen geometry, default paddle limits and step size,
// plus the quadrature decode helpers used by the paddle controller.
package quad_paddle_pkg;

  localparam int SCREEN_H       = 480;
  localparam int PADDLE_H       = 64;
  localparam int POS_MIN_DEF    = 0;
  localparam int POS_MAX_DEF    = SCREEN_H - PADDLE_H;  // 416
  localparam int POS_INIT_DEF   = 208;
  localparam int STEP_DEF       = 4;
  localparam int FILTER_LEN_DEF = 4;

  // Internal position width: one bit wider than paddle_y so pos+STEP never wraps.
  localparam int POS_W = 11;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    MOVE_IDLE    = 2'd0,
    MOVE_UP      = 2'd1,
    MOVE_DOWN    = 2'd2,
    MOVE_ILLEGAL = 2'd3
  } move_e;

  // Position of a phase pair in the up cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_idx(input logic a, input logic b);
    return {a, a ^ b};
  endfunction

  // Classify the transition prev_ab -> cur_ab (bit 1 = A, bit 0 = B).
  function automatic move_e decode_move(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
    logic [1:0] p;
    logic [1:0] c;
    p = gray_idx(prev_ab[1], prev_ab[0]);
    c = gray_idx(cur_ab[1], cur_ab[0]);
    if (c == p)               return MOVE_IDLE;
    else if (c == p + 2'd1)   return MOVE_UP;
    else if (p == c + 2'd1)   return MOVE_DOWN;
    else                      return MOVE_ILLEGAL;  // both phases changed
  endfunction

endpackage

// File: rtl/quad_paddle_filter.sv
// quad_filter: two-flop synchronizer followed by a stability filter for one
// encoder phase.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   async_i : asynchronous phase input
//   sync_o  : synchronizer output (second flop)
//   filt_o  : filtered phase, follows sync_o once it has been stable long enough
module quad_filter
  import quad_paddle_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic filt_o
);

  localparam logic [4:0] FLEN = 5'(FILTER_LEN);

  logic       meta_q;
  logic       sync_q;
  logic       sync_prev_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  // The counter restarts whenever the synced value agrees with the filtered
  // value or has just moved, so only an uninterrupted run is accepted. The
  // filtered value is taken on the edge where the count reaches FILTER_LEN.
  always_comb begin
    cnt_d  = cnt_inc[3:0];
    filt_d = filt_q;
    if ((sync_q == filt_q) || (sync_q != sync_prev_q)) begin
      cnt_d = '0;
    end else if (cnt_inc == FLEN) begin
      cnt_d  = '0;
      filt_d = sync_q;
    end
  end

  always_ff @(posedge clk_i) begin
    // The synchronizer keeps running through reset so the filter can be
    // primed with the real input level.
    meta_q      <= async_i;
    sync_q      <= meta_q;
    sync_prev_q <= sync_q;
    if (!rst_ni) begin
      filt_q <= sync_q;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = sync_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/quad_paddle.sv
// quad_paddle: turns a quadrature encoder into a clamped paddle position that
// is updated for the renderer only at frame boundaries.
//   CLOCK_50    : 50 MHz clock
//   RESET       : synchronous active-low reset
//   QUAD_A/B    : asynchronous encoder phases
//   frame_start : one-cycle pulse at start of vertical blanking
//   paddle_y    : frame-stable paddle position
//   step        : one-cycle pulse per accepted move (also at a limit)
//   dir         : direction of last accepted move, 1 = up (+)
//   err_count   : saturating count of illegal double-phase transitions
module quad_paddle
  import quad_paddle_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int POS_MIN    = POS_MIN_DEF,
  parameter int POS_MAX    = POS_MAX_DEF,
  parameter int POS_INIT   = POS_INIT_DEF,
  parameter int STEP       = STEP_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       QUAD_A,
  input  logic       QUAD_B,
  input  logic       frame_start,
  output logic [9:0] paddle_y,
  output logic       step,
  output logic       dir,
  output logic [7:0] err_count
);

  localparam logic [POS_W-1:0] P_MIN  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_INIT = POS_W'(POS_INIT);
  localparam logic [POS_W-1:0] P_STEP = POS_W'(STEP);
  localparam logic [POS_W-1:0] P_LOW  = POS_W'(POS_MIN + STEP);

  logic sync_a, sync_b, filt_a, filt_b;

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET),
    .async_i (QUAD_A),
    .sync_o  (sync_a),
    .filt_o  (filt_a)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET),
    .async_i (QUAD_B),
    .sync_o  (sync_b),
    .filt_o  (filt_b)
  );

  logic [1:0]       prev_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [9:0]       paddle_q, paddle_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [POS_W-1:0] up_sum;
  move_e            move;

  assign move   = decode_move(prev_q, {filt_a, filt_b});
  assign up_sum = pos_q + P_STEP;

  always_comb begin
    pos_d  = pos_q;
    step_d = 1'b0;
    dir_d  = dir_q;
    err_d  = err_q;
    case (move)
      MOVE_UP: begin
        pos_d  = (up_sum > P_MAX) ? P_MAX : up_sum;
        step_d = 1'b1;
        dir_d  = 1'b1;
      end
      MOVE_DOWN: begin
        pos_d  = (pos_q < P_LOW) ? P_MIN : (pos_q - P_STEP);
        step_d = 1'b1;
        dir_d  = 1'b0;
      end
      MOVE_ILLEGAL: begin
        if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
      end
      default: ;
    endcase
    // Sampling pos_q (not pos_d) gives the pre-move value when a move and
    // frame_start land on the same edge.
    paddle_d = frame_start ? pos_q[9:0] : paddle_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      // Prime the previous-phase register from the same synchronizer outputs
      // the filters load, so release never decodes a phantom move.
      prev_q   <= {sync_a, sync_b};
      pos_q    <= P_INIT;
      paddle_q <= P_INIT[9:0];
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      prev_q   <= {filt_a, filt_b};
      pos_q    <= pos_d;
      paddle_q <= paddle_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign paddle_y  = paddle_q;
  assign step      = step_q;
  assign dir       = dir_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_quad_paddle.sv
module tb_quad_paddle;

  localparam int F = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       quad_a, quad_b, frame_start;
  logic [9:0] paddle_y;
  logic       step, dir;
  logic [7:0] err_count;

  always #10 clk = ~clk;

  quad_paddle #(
    .FILTER_LEN(F), .POS_MIN(0), .POS_MAX(416), .POS_INIT(208), .STEP(4)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst_n),
    .QUAD_A      (quad_a),
    .QUAD_B      (quad_b),
    .frame_start (frame_start),
    .paddle_y    (paddle_y),
    .step        (step),
    .dir         (dir),
    .err_count   (err_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int cur_idx  = 0;
  logic [9:0] exp_q[$];

  always @(negedge clk) if (rst_n && step) step_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_ab(input logic a, input logic b, input int hold);
    quad_a = a;
    quad_b = b;
    repeat (hold) @(negedge clk);
  endtask

  // Up order 00 -> 01 -> 11 -> 10.
  task automatic drive_idx(input int idx, input int hold);
    cur_idx = idx & 3;
    case (cur_idx)
      0:       drive_ab(1'b0, 1'b0, hold);
      1:       drive_ab(1'b0, 1'b1, hold);
      2:       drive_ab(1'b1, 1'b1, hold);
      default: drive_ab(1'b1, 1'b0, hold);
    endcase
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       a;
    logic       b;
    int         hold;
    logic       frame;
    int         exp_steps;
    logic       exp_dir;
    logic [9:0] exp_y;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int s0;
    vecs[0] = '{1'b0, 1'b1, 20, 1'b0, 1, 1'b1, 10'd208, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 20, 1'b0, 1, 1'b1, 10'd208, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 20, 1'b0, 1, 1'b1, 10'd208, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 20, 1'b1, 1, 1'b1, 10'd224, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 20, 1'b1, 1, 1'b0, 10'd220, 8'd0};
    vecs[5] = '{1'b1, 1'b1, 20, 1'b1, 1, 1'b0, 10'd216, 8'd0};
    vecs[6] = '{1'b1, 1'b1, 20, 1'b1, 0, 1'b0, 10'd216, 8'd0};
    vecs[7] = '{1'b0, 1'b0, 20, 1'b1, 0, 1'b0, 10'd216, 8'd1};
    vecs[8] = '{1'b0, 1'b1, 20, 1'b1, 1, 1'b1, 10'd220, 8'd1};

    rst_n = 1'b1; quad_a = 1'b0; quad_b = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);   // let the synchronizers see the input level
    do_reset();

    // Reset state.
    check("rst_paddle_y", paddle_y, 208);
    check("rst_err", err_count, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    repeat (10) @(negedge clk);
    check("rst_no_step", step_cnt, 0);

    // Table-driven moves.
    for (int i = 0; i < 9; i++) begin
      s0 = step_cnt;
      drive_ab(vecs[i].a, vecs[i].b, vecs[i].hold);
      if (vecs[i].frame) pulse_frame();
      check($sformatf("v%0d_steps", i), step_cnt - s0, vecs[i].exp_steps);
      check($sformatf("v%0d_dir", i), dir, vecs[i].exp_dir);
      check($sformatf("v%0d_paddle", i), paddle_y, vecs[i].exp_y);
      check($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
    end
    cur_idx = 1;  // phases now 01, pos 220

    // Glitch of FILTER_LEN-1 cycles on A.
    s0 = step_cnt;
    drive_ab(1'b1, 1'b1, F - 1);
    drive_ab(1'b0, 1'b1, 20);
    pulse_frame();
    check("glitch_steps", step_cnt - s0, 0);
    check("glitch_err", err_count, 1);
    check("glitch_paddle", paddle_y, 220);

    // Latency: step must rise exactly after edge k+F+3.
    quad_a = 1'b1; quad_b = 1'b1; cur_idx = 2;   // 01 -> 11, pos 224
    for (int j = 0; j <= F + 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_step_e%0d", j), step, (j == F + 3) ? 1 : 0);
    end
    repeat (10) @(negedge clk);

    // Move coinciding with frame_start: renderer gets the pre-move position.
    quad_a = 1'b1; quad_b = 1'b0; cur_idx = 3;   // 11 -> 10, pos 228
    repeat (F + 3) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("coin_step", step, 1);
    check("coin_paddle_pre", paddle_y, 224);
    repeat (5) @(negedge clk);
    pulse_frame();
    check("coin_paddle_post", paddle_y, 228);

    // Frame-stable output across encoder activity.
    do_reset();
    check("r2_paddle", paddle_y, 208);
    drive_idx(cur_idx + 1, 12);   // step at k+7, frame sampled at k+12
    pulse_frame();
    check("fs_first", paddle_y, 212);
    for (int e = 0; e < 10; e++) begin
      exp_q.push_back(10'd212);
      drive_idx(cur_idx + 1, 10);
      check($sformatf("fs_hold_e%0d", e), paddle_y, exp_q.pop_front());
    end
    pulse_frame();
    check("fs_second", paddle_y, 252);
    check("fs_dir", dir, 1);

    // Down to the lower limit; step keeps pulsing at the clamp.
    do_reset();
    s0 = step_cnt;
    for (int e = 0; e < 52; e++) drive_idx(cur_idx + 3, 8);
    repeat (4) @(negedge clk);
    check("down_steps_52", step_cnt - s0, 52);
    s0 = step_cnt;
    for (int e = 0; e < 8; e++) drive_idx(cur_idx + 3, 8);
    repeat (4) @(negedge clk);
    check("down_steps_at_limit", step_cnt - s0, 8);
    check("down_dir", dir, 0);
    pulse_frame();
    check("down_paddle", paddle_y, 0);

    // Illegal transitions saturate the error counter.
    do_reset();
    s0 = step_cnt;
    for (int e = 0; e < 300; e++) drive_idx(cur_idx + 2, 8);
    repeat (4) @(negedge clk);
    check("err_sat", err_count, 255);
    check("err_steps", step_cnt - s0, 0);
    pulse_frame();
    check("err_paddle", paddle_y, 208);

    // Reset landing on the edge that would have produced a step.
    drive_idx(cur_idx + 1, F + 3);
    do_reset();
    s0 = step_cnt;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("rmid_step_c%0d", c), step, 0);
      @(negedge clk);
    end
    check("rmid_steps", step_cnt - s0, 0);
    check("rmid_err", err_count, 0);
    pulse_frame();
    check("rmid_paddle", paddle_y, 208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
